axi_lfsr_mem_responder: RTL and testbench
=========================================

// Module: axi_lfsr_mem_responder
// PURPOSE
// - AXI4 slave counterpart to the LFSR memory checker. Bench/BIST target in the LPDDR4 test path: stands in for the DDR controller.
// - Every write beat is checked against an internally regenerated LFSR pattern. Every read beat is answered with the same pattern.
// - No storage. Pass/fail is reported through sticky flags and counters.
// PARAMETERS
// - DW 512: data width. Fixed at 4x the 128-bit LFSR.
// - IDW 6: AXI ID width.
// - AW 33: address width.
// - RD_LAT 4: cycles from AR accept to first rvalid, 1..15.
// PORTS
// axi_clk       in   1     sole clock
// rstn          in   1     asynchronous active-low reset
// awid/awaddr   in   6/33  write address channel
// awlen/awsize  in   8/3   beats-1; must be 6 (64 B)
// awburst       in   2     must be 2'b01 (INCR)
// awvalid/awready  in/out  1  AW handshake
// wdata/wstrb   in   512/64  write data; wstrb must be all-ones
// wlast/wvalid  in   1     W channel
// wready        out  1     W ready
// bid/bresp     out  6/2   write response
// bvalid/bready out/in  1  B handshake
// arid/araddr   in   6/33  read address channel
// arlen/arsize/arburst  in  8/3/2  same rules as AW
// arvalid/arready  in/out  1  AR handshake
// rid/rdata     out  6/512 read data
// rresp/rlast   out  2/1   read response / last beat
// rvalid/rready out/in  1  R handshake
// lfsr_seed     in   128   pattern seed
// lfsr_en       in   1     1 = advancing LFSR; 0 = constant seed pattern
// check_mask    in   32    replicated 16x; only masked bits are compared or driven
// wr_mismatch   out  1     sticky: any masked write beat differed
// prot_err      out  1     sticky: bad size/burst/strobe/wlast
// mism_cnt      out  32    count of mismatching write beats, saturates at max
// wr_beats/rd_beats  out 32/32  completed beat counters, wrap modulo 2^32
// BEHAVIOUR
// - Reset: awready=arready=wready=bvalid=rvalid=rlast=0; bid=rid=0; bresp=rresp=0; rdata=0; all flags and counters 0; both LFSRs = 0.
// - Pattern: pat(L) = {4{lfsr_en ? L : lfsr_seed}} & {16{check_mask}}.
// - LFSR step: L <= {L[126:0], L[98] ~^ L[100] ~^ L[125] ~^ L[127]}.
// - Write and read LFSRs are independent. Each is loaded with lfsr_seed when its burst is accepted with address==0. Otherwise it continues from the prior burst.
// - Write FSM WI->WD->WB->WI:
//   - WI: awready=1. On awvalid, latch id and len, set beat cnt=0, compute err from size/burst, go to WD (awready=0 next cycle).
//   - WD: wready=1. On wvalid, compare (wdata & mask) vs pat(wr_lfsr). On mismatch set wr_mismatch and increment mism_cnt. Step wr_lfsr, increment wr_beats.
//   - WD: a beat with wstrb != all-ones, or wlast != (cnt==len), sets err and prot_err.
//   - WD: exit to WB after beat cnt==len. An early wlast does not end the burst; the burst ends on count.
//   - WB: bvalid=1, bid=latched id, bresp = err ? 2'b10 : 2'b00. Hold until bready, then go to WI.
//   - Data mismatches never alter bresp.
// - Read FSM RI->RL->RD->RI:
//   - RI: arready=1. On arvalid, latch id/len/err, go to RL.
//   - RL: wait RD_LAT-1 cycles, then go to RD.
//   - RD: rvalid=1, rdata=pat(rd_lfsr), rid=latched id, rresp=err?2'b10:2'b00, rlast=(cnt==len).
//   - RD: all outputs stay stable while rvalid & ~rready. On rvalid&rready, step rd_lfsr and increment rd_beats. On the last beat, go to RI with rvalid=0 next cycle.
// - Both FSMs run concurrently. Only one burst is outstanding per direction.
// - No write-before-read ordering is enforced.
// - A changed lfsr_seed takes effect only at the next address-0 burst.
// - Reset mid-burst: everything returns to reset values immediately. No response is issued for an aborted burst.
// STRUCTURE
// - Package axi_lfsr_pkg holds:
//   - LFSR width and taps.
//   - lfsr_step() function.
//   - AXI_RESP_OKAY / AXI_RESP_SLVERR.
//   - BURST_INCR and ASIZE_64B constants.
// - Sub-module lfsr_pattern_gen: holds one LFSR; inputs load/step/seed/en/mask; output pattern. Instantiated twice (write, read).
// TESTING
// - Seed 0x1 with lfsr_en=1, mask 0xFFFFFFFF. One 256-beat write at address 0 carrying the checker-generated pattern -> wr_mismatch=0, wr_beats=256, bresp=00.
// - Same burst with bit 5 flipped on beat 17 only -> mism_cnt=1, wr_mismatch=1, bresp=00.
// - Repeat with mask 0xFFFFFFDF -> mism_cnt=0.
// - Read of 256 beats at address 0, then 256 at address 0x4000. Hold rready low for 3 cycles at beat 10 -> rdata equals pat, stable while stalled; continuous across both bursts; rlast only on beat 255; first rvalid RD_LAT cycles after AR accept.
// - awburst=2'b00 with wlast early at beat 3 of a 4-beat burst -> bresp=2'b10, prot_err=1, all 4 beats consumed.
// - lfsr_en=0, seed 0xA5..A5 -> every rdata beat = {4{seed}} & mask.
// - Write and read issued in the same cycle -> both complete independently with the correct bid/rid.
// - rstn pulsed low during beat 100 of a read -> rvalid=0 immediately. A new AR is accepted after release.

Source files
------------

// File: rtl/axi_lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Package : axi_lfsr_pkg
// Brief   : LFSR geometry, step function and AXI encodings shared by the
//           LFSR memory responder and its pattern generators.
// Rev     : 1.0
// ============================================================================
package axi_lfsr_pkg;

    localparam int LFSR_W = 128;
    localparam int TAP_0  = 98;
    localparam int TAP_1  = 100;
    localparam int TAP_2  = 125;
    localparam int TAP_3  = 127;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR      = 2'b01;
    localparam logic [2:0] ASIZE_64B       = 3'd6;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_LAT  = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], cur[TAP_0] ~^ cur[TAP_1] ~^ cur[TAP_2] ~^ cur[TAP_3]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module : lfsr_pattern_gen
// Brief  : One 128-bit LFSR expanded to a masked data-width pattern.
// Rev    : 1.0
// ============================================================================
module lfsr_pattern_gen
    import axi_lfsr_pkg::*;
#(
    parameter int DW = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [LFSR_W-1:0] seed,
    input  logic              en,
    input  logic [31:0]       mask,
    output logic [DW-1:0]     pattern
);

    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= '0;
        end else if (load) begin
            lfsr <= seed;
        end else if (step) begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    // With the LFSR disabled the live seed is used, so the pattern is constant.
    assign base    = en ? lfsr : seed;
    assign pattern = {(DW/LFSR_W){base}} & {(DW/32){mask}};

endmodule
`default_nettype wire

// File: rtl/axi_lfsr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module : axi_lfsr_mem_responder
// Brief  : Storage-less AXI4 slave: checks write beats against and answers
//          read beats with a regenerated LFSR pattern.
// Rev    : 1.0
// ============================================================================
module axi_lfsr_mem_responder
    import axi_lfsr_pkg::*;
#(
    parameter int DW     = 512,
    parameter int IDW    = 6,
    parameter int AW     = 33,
    parameter int RD_LAT = 4
) (
    input  logic              axi_clk,
    input  logic              rstn,
    input  logic [IDW-1:0]    awid,
    input  logic [AW-1:0]     awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DW-1:0]     wdata,
    input  logic [DW/8-1:0]   wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [IDW-1:0]    bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [IDW-1:0]    arid,
    input  logic [AW-1:0]     araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [IDW-1:0]    rid,
    output logic [DW-1:0]     rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [LFSR_W-1:0] lfsr_seed,
    input  logic              lfsr_en,
    input  logic [31:0]       check_mask,
    output logic              wr_mismatch,
    output logic              prot_err,
    output logic [31:0]       mism_cnt,
    output logic [31:0]       wr_beats,
    output logic [31:0]       rd_beats
);

    wr_state_t      wr_state, wr_next;
    rd_state_t      rd_state, rd_next;
    logic           live;
    logic [IDW-1:0] wr_id, rd_id;
    logic [7:0]     wr_len, wr_cnt, rd_len, rd_cnt;
    logic           wr_err, rd_err;
    logic [3:0]     lat_cnt;
    logic [DW-1:0]  wr_pat, rd_pat, data_mask;
    logic           aw_fire, w_fire, ar_fire, r_fire;
    logic           wr_last, rd_last, aw_bad, ar_bad, w_bad, w_mism;

    assign aw_fire   = awvalid & awready;
    assign w_fire    = wvalid & wready;
    assign ar_fire   = arvalid & arready;
    assign r_fire    = rvalid & rready;
    assign wr_last   = (wr_cnt == wr_len);
    assign rd_last   = (rd_cnt == rd_len);
    assign aw_bad    = (awsize != ASIZE_64B) || (awburst != BURST_INCR);
    assign ar_bad    = (arsize != ASIZE_64B) || (arburst != BURST_INCR);
    assign w_bad     = (wstrb != '1) || (wlast != wr_last);
    assign data_mask = {(DW/32){check_mask}};
    assign w_mism    = (wdata & data_mask) != wr_pat;

    // Holds both address channels off while in reset and for the first cycle after.
    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn) live <= 1'b0;
        else       live <= 1'b1;
    end

    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    always_comb begin
        wr_next = wr_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                awready = live;
                if (awvalid && live) wr_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && wr_last) wr_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        rd_next = rd_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (rd_state)
            R_IDLE: begin
                arready = live;
                if (arvalid && live) rd_next = (RD_LAT == 1) ? R_DATA : R_LAT;
            end
            R_LAT: begin
                if (lat_cnt <= 4'd1) rd_next = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready && rd_last) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn) begin
            wr_id  <= '0;
            wr_len <= '0;
            wr_cnt <= '0;
            wr_err <= 1'b0;
        end else if (aw_fire) begin
            wr_id  <= awid;
            wr_len <= awlen;
            wr_cnt <= '0;
            wr_err <= aw_bad;
        end else if (w_fire) begin
            wr_cnt <= wr_cnt + 8'd1;
            if (w_bad) wr_err <= 1'b1;
        end
    end

    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn) begin
            rd_id   <= '0;
            rd_len  <= '0;
            rd_cnt  <= '0;
            rd_err  <= 1'b0;
            lat_cnt <= '0;
        end else if (ar_fire) begin
            rd_id   <= arid;
            rd_len  <= arlen;
            rd_cnt  <= '0;
            rd_err  <= ar_bad;
            lat_cnt <= 4'(RD_LAT - 1);
        end else begin
            if (rd_state == R_LAT) lat_cnt <= lat_cnt - 4'd1;
            if (r_fire)            rd_cnt  <= rd_cnt + 8'd1;
        end
    end

    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn) begin
            wr_mismatch <= 1'b0;
            prot_err    <= 1'b0;
            mism_cnt    <= '0;
            wr_beats    <= '0;
            rd_beats    <= '0;
        end else begin
            if ((aw_fire && aw_bad) || (ar_fire && ar_bad) || (w_fire && w_bad))
                prot_err <= 1'b1;
            if (w_fire) begin
                wr_beats <= wr_beats + 32'd1;
                if (w_mism) begin
                    wr_mismatch <= 1'b1;
                    if (mism_cnt != '1) mism_cnt <= mism_cnt + 32'd1;
                end
            end
            if (r_fire) rd_beats <= rd_beats + 32'd1;
        end
    end

    // Data mismatches are reported only through the flags, never through bresp.
    assign bid   = wr_id;
    assign bresp = (bvalid && wr_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign rid   = rd_id;
    assign rresp = (rvalid && rd_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign rlast = rvalid && rd_last;
    assign rdata = rvalid ? rd_pat : '0;

    lfsr_pattern_gen #(.DW(DW)) u_wr_gen (
        .clk     (axi_clk),
        .rst_n   (rstn),
        .load    (aw_fire && (awaddr == '0)),
        .step    (w_fire),
        .seed    (lfsr_seed),
        .en      (lfsr_en),
        .mask    (check_mask),
        .pattern (wr_pat)
    );

    lfsr_pattern_gen #(.DW(DW)) u_rd_gen (
        .clk     (axi_clk),
        .rst_n   (rstn),
        .load    (ar_fire && (araddr == '0)),
        .step    (r_fire),
        .seed    (lfsr_seed),
        .en      (lfsr_en),
        .mask    (check_mask),
        .pattern (rd_pat)
    );

endmodule
`default_nettype wire

// File: tb/tb_axi_lfsr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_lfsr_mem_responder
// Brief  : Directed + randomized self-checking bench with a pattern model.
// Rev    : 1.0
// ============================================================================
module tb_axi_lfsr_mem_responder;

    localparam int DW     = 512;
    localparam int IDW    = 6;
    localparam int AW     = 33;
    localparam int RD_LAT = 4;

    logic            axi_clk = 1'b0;
    logic            rstn;
    logic [IDW-1:0]  awid = '0, arid = '0, bid, rid;
    logic [AW-1:0]   awaddr = '0, araddr = '0;
    logic [7:0]      awlen = '0, arlen = '0;
    logic [2:0]      awsize = 3'd6, arsize = 3'd6;
    logic [1:0]      awburst = 2'b01, arburst = 2'b01, bresp, rresp;
    logic            awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
    logic            bvalid, bready = 1'b0, arvalid = 1'b0, arready;
    logic            rlast, rvalid, rready = 1'b0;
    logic [DW-1:0]   wdata = '0, rdata;
    logic [DW/8-1:0] wstrb = '1;
    logic [127:0]    lfsr_seed = 128'h1;
    logic            lfsr_en = 1'b1;
    logic [31:0]     check_mask = 32'hFFFF_FFFF;
    logic            wr_mismatch, prot_err;
    logic [31:0]     mism_cnt, wr_beats, rd_beats;

    int checks = 0;
    int errors = 0;

    // Reference state, derived from the pattern rules rather than the RTL.
    logic [127:0] m_wr, m_rd;
    int unsigned  m_wr_beats, m_rd_beats, m_mism;
    bit           m_wrm, m_prot;

    always #5 axi_clk = ~axi_clk;

    axi_lfsr_mem_responder #(.DW(DW), .IDW(IDW), .AW(AW), .RD_LAT(RD_LAT)) dut (
        .axi_clk(axi_clk), .rstn(rstn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .lfsr_seed(lfsr_seed), .lfsr_en(lfsr_en), .check_mask(check_mask),
        .wr_mismatch(wr_mismatch), .prot_err(prot_err), .mism_cnt(mism_cnt),
        .wr_beats(wr_beats), .rd_beats(rd_beats)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mstep(input logic [127:0] l);
        logic fb;
        fb = ~(l[98] ^ l[100] ^ l[125] ^ l[127]);
        return {l[126:0], fb};
    endfunction

    function automatic logic [DW-1:0] mpat(input logic [127:0] l);
        logic [127:0] b;
        b = lfsr_en ? l : lfsr_seed;
        return {4{b}} & {16{check_mask}};
    endfunction

    function automatic logic [DW-1:0] rnd512();
        logic [DW-1:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_wr = '0; m_rd = '0; m_wr_beats = 0; m_rd_beats = 0;
        m_mism = 0; m_wrm = 1'b0; m_prot = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge axi_clk);
        rstn = 1'b0;
        repeat (3) @(negedge axi_clk);
        chk("rst_awready", awready, 0);   chk("rst_arready", arready, 0);
        chk("rst_wready", wready, 0);     chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);     chk("rst_rlast", rlast, 0);
        chk("rst_bid", bid, 0);           chk("rst_rid", rid, 0);
        chk("rst_bresp", bresp, 0);       chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);       chk("rst_wr_mismatch", wr_mismatch, 0);
        chk("rst_prot_err", prot_err, 0); chk("rst_mism_cnt", mism_cnt, 0);
        chk("rst_wr_beats", wr_beats, 0); chk("rst_rd_beats", rd_beats, 0);
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic do_write(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input int len,
                            input logic [1:0] burst, input int flip_beat, input int flip_bit,
                            input int early_last, input int bad_strb_beat, input bit gaps);
        logic [DW-1:0] d, ep, m;
        logic          wl, err;
        int            t;
        err = (burst != 2'b01);
        @(negedge axi_clk);
        awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'd6; awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 200) begin @(negedge axi_clk); t++; end
        chk("aw_handshake", awready, 1);
        @(negedge axi_clk);
        awvalid = 1'b0;
        if (err) m_prot = 1'b1;
        if (addr == '0) m_wr = lfsr_seed;
        m = {16{check_mask}};
        for (int b = 0; b <= len; b++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin wvalid = 1'b0; @(negedge axi_clk); end
            ep = mpat(m_wr);
            d  = ({4{lfsr_en ? m_wr : lfsr_seed}} & m) | (rnd512() & ~m);
            if (b == flip_beat) d[flip_bit] = ~d[flip_bit];
            wl = (early_last >= 0) ? (b == early_last) : (b == len);
            if ((b == bad_strb_beat) || (wl != (b == len))) begin err = 1'b1; m_prot = 1'b1; end
            if ((d & m) != ep) begin
                m_wrm = 1'b1;
                if (m_mism != 32'hFFFF_FFFF) m_mism++;
            end
            wdata = d; wlast = wl; wvalid = 1'b1;
            wstrb = (b == bad_strb_beat) ? {{(DW/8-1){1'b1}}, 1'b0} : '1;
            t = 0;
            while (!wready && t < 200) begin @(negedge axi_clk); t++; end
            chk("w_handshake", wready, 1);
            @(negedge axi_clk);
            m_wr = mstep(m_wr);
            m_wr_beats++;
        end
        wvalid = 1'b0; wlast = 1'b0; wstrb = '1;
        chk("wready_after_last", wready, 0);
        t = 0;
        while (!bvalid && t < 50) begin @(negedge axi_clk); t++; end
        chk("bvalid", bvalid, 1);
        if (gaps) repeat ($urandom_range(0, 3)) begin
            @(negedge axi_clk);
            chk("bvalid_hold", bvalid, 1);
        end
        chk("bid", bid, id);
        chk("bresp", bresp, err ? 2'b10 : 2'b00);
        bready = 1'b1;
        @(negedge axi_clk);
        bready = 1'b0;
        chk("bvalid_drop", bvalid, 0);
        chk("wr_beats", wr_beats, m_wr_beats);
        chk("mism_cnt", mism_cnt, m_mism);
        chk("wr_mismatch", wr_mismatch, m_wrm);
        chk("prot_err_w", prot_err, m_prot);
    endtask

    task automatic do_read(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input int len,
                           input logic [2:0] size, input int stall_beat, input int stall_n,
                           input int abort_beat, input bit rand_ready);
        int b, k, st, cyc, t;
        logic err;
        err = (size != 3'd6);
        @(negedge axi_clk);
        arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = 2'b01; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 200) begin @(negedge axi_clk); t++; end
        chk("ar_handshake", arready, 1);
        @(negedge axi_clk);
        arvalid = 1'b0;
        if (err) m_prot = 1'b1;
        if (addr == '0) m_rd = lfsr_seed;
        k = 1;
        while (!rvalid && k < 40) begin @(negedge axi_clk); k++; end
        chk("rd_latency", k, RD_LAT);
        b = 0; st = stall_n; cyc = 0;
        while (b <= len && cyc < 5000) begin
            if (b == abort_beat) begin
                rstn = 1'b0;
                #1;
                chk("abort_rvalid", rvalid, 0);
                chk("abort_rd_beats", rd_beats, 0);
                chk("abort_arready", arready, 0);
                @(negedge axi_clk);
                rstn = 1'b1; rready = 1'b0;
                model_reset();
                return;
            end
            chk("rvalid", rvalid, 1);
            chk("rdata", rdata, mpat(m_rd));
            chk("rid", rid, id);
            chk("rresp", rresp, err ? 2'b10 : 2'b00);
            chk("rlast", rlast, (b == len));
            if (b == stall_beat && st > 0) begin
                rready = 1'b0; st--;
            end else begin
                rready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (rready) begin m_rd = mstep(m_rd); m_rd_beats++; b++; end
            @(negedge axi_clk);
            cyc++;
        end
        rready = 1'b0;
        chk("rvalid_after_last", rvalid, 0);
        chk("rd_beats", rd_beats, m_rd_beats);
        chk("prot_err_r", prot_err, m_prot);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b1;
        model_reset();
        #2 rstn = 1'b0;
        do_reset();

        lfsr_seed = 128'h1; lfsr_en = 1'b1; check_mask = 32'hFFFF_FFFF;
        do_write(6'h01, '0, 255, 2'b01, -1, 0, -1, -1, 1'b0);
        do_write(6'h02, '0, 255, 2'b01, 17, 5, -1, -1, 1'b1);

        do_reset();
        check_mask = 32'hFFFF_FFDF;
        do_write(6'h03, '0, 255, 2'b01, 17, 5, -1, -1, 1'b0);

        check_mask = 32'hFFFF_FFFF;
        do_read(6'h04, '0, 255, 3'd6, 10, 3, -1, 1'b0);
        do_read(6'h05, 33'h4000, 255, 3'd6, -1, 0, -1, 1'b1);

        do_write(6'h06, 33'h100, 3, 2'b00, -1, 0, 2, -1, 1'b0);

        lfsr_en = 1'b0; lfsr_seed = {16{8'hA5}};
        do_read(6'h07, 33'h200, 7, 3'd6, -1, 0, -1, 1'b1);

        lfsr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lfsr_seed  = rnd128();
            check_mask = $urandom;
            do_write(6'($urandom), ($urandom_range(0, 1) == 0) ? '0 : 33'h80, $urandom_range(0, 15),
                     2'b01, $urandom_range(0, 20), $urandom_range(0, 511), -1,
                     ($urandom_range(0, 2) == 0) ? 1 : -1, 1'b1);
            do_read(6'($urandom), ($urandom_range(0, 1) == 0) ? '0 : 33'h40, $urandom_range(0, 15),
                    ($urandom_range(0, 3) == 0) ? 3'd5 : 3'd6, -1, 0, -1, 1'b1);
        end

        check_mask = 32'hFFFF_FFFF;
        lfsr_seed  = rnd128();
        fork
            do_write(6'h2A, '0, 7, 2'b01, -1, 0, -1, -1, 1'b1);
            do_read(6'h15, '0, 7, 3'd6, -1, 0, -1, 1'b1);
        join

        do_read(6'h09, '0, 255, 3'd6, -1, 0, 100, 1'b0);
        do_read(6'h0A, 33'h80, 3, 3'd6, -1, 0, -1, 1'b1);
        chk("final_wr_beats", wr_beats, m_wr_beats);
        chk("final_prot_err", prot_err, m_prot);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
